// File: rtl/ps2_scancode_decoder_if.sv
// Bundles the byte input from ps2_controller and the character output toward data_control.
// master = producer/consumer side (drives bytes, accepts chars); slave = the decoder.
interface ps2_scancode_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Byte side: ps2_received_data is meaningful only in a cycle with ps2_received_data_strb=1.
    // Char side: valid/ready; char_data transfers at a rising edge where char_valid & char_ready,
    // char_valid never depends on char_ready, and char_data holds while valid without a transfer.
    logic [7:0]     ps2_received_data;
    logic           ps2_received_data_strb;
    logic [7:0]     char_data;
    logic           char_valid;
    logic           char_ready;
    logic [PTR_W:0] fifo_level;
    logic           overflow;

    modport master (
        output ps2_received_data,
        output ps2_received_data_strb,
        output char_ready,
        input  char_data,
        input  char_valid,
        input  fifo_level,
        input  overflow
    );

    modport slave (
        input  ps2_received_data,
        input  ps2_received_data_strb,
        input  char_ready,
        output char_data,
        output char_valid,
        output fifo_level,
        output overflow
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode to uppercase ASCII decoder with an output character FIFO.
// Optional typematic-repeat suppression is built when PS2_REPEAT_FILTER_EN is defined.
module ps2_scancode_decoder #(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ps2_scancode_decoder_if.slave   bus,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [8:0]     w_lut;
    logic           w_make_hit;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_wr_en;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0] r_count;
    logic           r_overflow;
    logic [7:0]     w_byte;
    logic           w_strb;

    assign w_byte = bus.ps2_received_data;
    assign w_strb = bus.ps2_received_data_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_strb) begin
            case (r_state)
                S_IDLE: begin
                    if (w_byte == 8'hF0)      w_state_nxt = S_BREAK;
                    else if (w_byte == 8'hE0) w_state_nxt = S_EXT;
                end
                S_BREAK:     w_state_nxt = S_IDLE;
                S_EXT:       w_state_nxt = (w_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
                S_EXT_BREAK: w_state_nxt = S_IDLE;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_dbg_state = r_state;

    // Bit 8 flags a mapped code; bits 7:0 hold the ASCII character.
    always_comb begin
        w_lut = 9'h000;
        case (w_byte)
            8'h1C: w_lut = {1'b1, 8'h41};
            8'h32: w_lut = {1'b1, 8'h42};
            8'h21: w_lut = {1'b1, 8'h43};
            8'h23: w_lut = {1'b1, 8'h44};
            8'h24: w_lut = {1'b1, 8'h45};
            8'h2B: w_lut = {1'b1, 8'h46};
            8'h34: w_lut = {1'b1, 8'h47};
            8'h33: w_lut = {1'b1, 8'h48};
            8'h43: w_lut = {1'b1, 8'h49};
            8'h3B: w_lut = {1'b1, 8'h4A};
            8'h42: w_lut = {1'b1, 8'h4B};
            8'h4B: w_lut = {1'b1, 8'h4C};
            8'h3A: w_lut = {1'b1, 8'h4D};
            8'h31: w_lut = {1'b1, 8'h4E};
            8'h44: w_lut = {1'b1, 8'h4F};
            8'h4D: w_lut = {1'b1, 8'h50};
            8'h15: w_lut = {1'b1, 8'h51};
            8'h2D: w_lut = {1'b1, 8'h52};
            8'h1B: w_lut = {1'b1, 8'h53};
            8'h2C: w_lut = {1'b1, 8'h54};
            8'h3C: w_lut = {1'b1, 8'h55};
            8'h2A: w_lut = {1'b1, 8'h56};
            8'h1D: w_lut = {1'b1, 8'h57};
            8'h22: w_lut = {1'b1, 8'h58};
            8'h35: w_lut = {1'b1, 8'h59};
            8'h1A: w_lut = {1'b1, 8'h5A};
            8'h45: w_lut = {1'b1, 8'h30};
            8'h16: w_lut = {1'b1, 8'h31};
            8'h1E: w_lut = {1'b1, 8'h32};
            8'h26: w_lut = {1'b1, 8'h33};
            8'h25: w_lut = {1'b1, 8'h34};
            8'h2E: w_lut = {1'b1, 8'h35};
            8'h36: w_lut = {1'b1, 8'h36};
            8'h3D: w_lut = {1'b1, 8'h37};
            8'h3E: w_lut = {1'b1, 8'h38};
            8'h46: w_lut = {1'b1, 8'h39};
            8'h29: w_lut = {1'b1, 8'h20};
            default: w_lut = 9'h000;
        endcase
    end

    // Only a mapped byte seen in IDLE is a make code; prefixes never reach the lookup.
    assign w_make_hit = w_strb && (r_state == S_IDLE) &&
                        (w_byte != 8'hF0) && (w_byte != 8'hE0) && w_lut[8];

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] r_last_code;
    logic       r_last_valid;
    logic       w_repeat;

    assign w_repeat = r_last_valid && (r_last_code == w_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_code  <= 8'h00;
            r_last_valid <= 1'b0;
        end else if (w_make_hit && !w_repeat) begin
            r_last_code  <= w_byte;
            r_last_valid <= 1'b1;
        end else if (w_strb && (r_state == S_BREAK) && (w_byte == r_last_code)) begin
            r_last_valid <= 1'b0;
        end
    end

    assign w_push = w_make_hit && !w_repeat;
`else
    assign w_push = w_make_hit;
`endif

    assign w_pop   = (r_count != '0) && bus.char_ready;
    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    // A pop frees the slot in the same edge, so a full FIFO still accepts a simultaneous push.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_lut[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign bus.char_valid = (r_count != '0);
    assign bus.char_data  = bus.char_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.fifo_level = r_count;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: scancode sequences with hand-computed ASCII,
// checked by direct probes and by a scoreboard on the char valid/ready side.
module tb_ps2_scancode_decoder;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;
    int pop_base;
    logic [7:0] exp_q[$];
    logic [7:0] exp_char;

    ps2_scancode_decoder_if #(.FIFO_DEPTH(4)) bus();

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 2 time units after a rising edge
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        bus.ps2_received_data      = b;
        bus.ps2_received_data_strb = 1'b1;
        @(posedge clk); #2;
        bus.ps2_received_data_strb = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #2;
        bus.char_ready = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // scoreboard: every accepted char must be the oldest expected one
    always @(negedge clk) begin
        if (rst_n && bus.char_valid && bus.char_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_char = exp_q.pop_front();
                check("sb_data", {24'd0, bus.char_data}, {24'd0, exp_char});
            end
        end
    end

    initial begin
        bus.ps2_received_data      = 8'h00;
        bus.ps2_received_data_strb = 1'b0;
        bus.char_ready             = 1'b0;
        rst_n                      = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_valid", {31'd0, bus.char_valid}, 32'd0);
        check("rst_data",  {24'd0, bus.char_data},  32'h00);
        check("rst_level", {29'd0, bus.fifo_level}, 32'd0);
        check("rst_ovf",   {31'd0, bus.overflow},   32'd0);
        check("rst_state", {30'd0, dbg_state},      32'd0);

        // a byte without strobe is ignored
        @(posedge clk); #2;
        bus.ps2_received_data = 8'h1C;
        repeat (2) @(negedge clk);
        check("nostrb_level", {29'd0, bus.fifo_level}, 32'd0);

        // test 1: single make code, immediate pop
        set_ready(1'b1);
        exp_q.push_back(8'h41);
        send_byte(8'h1C);
        @(negedge clk);
        check("t1_valid", {31'd0, bus.char_valid}, 32'd1);
        check("t1_data",  {24'd0, bus.char_data},  32'h41);
        check("t1_level", {29'd0, bus.fifo_level}, 32'd1);
        @(negedge clk);
        check("t1_level_after", {29'd0, bus.fifo_level}, 32'd0);
        check("t1_valid_after", {31'd0, bus.char_valid}, 32'd0);

        // test 2: break and extended sequences produce nothing
        pop_base = n_pop;
        exp_q.push_back(8'h41);
        send_byte(8'h1C);
        send_byte(8'hF0);
        @(negedge clk);
        check("t2_state_break", {30'd0, dbg_state}, 32'd1);
        send_byte(8'h1C);
        send_byte(8'hE0);
        @(negedge clk);
        check("t2_state_ext", {30'd0, dbg_state}, 32'd2);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        @(negedge clk);
        check("t2_state_extbrk", {30'd0, dbg_state}, 32'd3);
        send_byte(8'h75);
        send_byte(8'h07);
        repeat (3) @(negedge clk);
        check("t2_state_idle", {30'd0, dbg_state},      32'd0);
        check("t2_level",      {29'd0, bus.fifo_level}, 32'd0);
        check("t2_count",      n_pop - pop_base,        32'd1);

        // test 3: overflow with consumer stalled, then ordered drain
        set_ready(1'b0);
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        send_byte(8'h2E);
        @(negedge clk);
        check("t3_level", {29'd0, bus.fifo_level}, 32'd4);
        check("t3_ovf",   {31'd0, bus.overflow},   32'd1);
        check("t3_head",  {24'd0, bus.char_data},  32'h31);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h34);
        set_ready(1'b1);
        repeat (6) @(negedge clk);
        check("t3_drained", {29'd0, bus.fifo_level}, 32'd0);
        check("t3_ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        // test 5: reset in the middle of a break sequence
        set_ready(1'b0);
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1A);
        @(negedge clk);
        check("t5_data",  {24'd0, bus.char_data},  32'h5A);
        check("t5_ovf",   {31'd0, bus.overflow},   32'd0);
        check("t5_level", {29'd0, bus.fifo_level}, 32'd1);
        check("t5_state", {30'd0, dbg_state},      32'd0);
        exp_q.push_back(8'h5A);
        set_ready(1'b1);
        repeat (3) @(negedge clk);

        // test 4: full FIFO, push and pop in the same cycle
        set_ready(1'b0);
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        @(negedge clk);
        check("t4_full", {29'd0, bus.fifo_level}, 32'd4);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h20);
        @(posedge clk); #2;
        bus.ps2_received_data      = 8'h29;
        bus.ps2_received_data_strb = 1'b1;
        bus.char_ready             = 1'b1;
        @(posedge clk); #2;
        bus.ps2_received_data_strb = 1'b0;
        bus.char_ready             = 1'b0;
        @(negedge clk);
        check("t4_level", {29'd0, bus.fifo_level}, 32'd4);
        check("t4_ovf",   {31'd0, bus.overflow},   32'd0);
        check("t4_head",  {24'd0, bus.char_data},  32'h32);
        set_ready(1'b1);
        repeat (6) @(negedge clk);
        check("t4_drained", {29'd0, bus.fifo_level}, 32'd0);

        // test 6: typematic repeats
        pop_base = n_pop;
`ifdef PS2_REPEAT_FILTER_EN
        repeat (2) exp_q.push_back(8'h41);
`else
        repeat (4) exp_q.push_back(8'h41);
`endif
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        repeat (4) @(negedge clk);
`ifdef PS2_REPEAT_FILTER_EN
        check("t6_count", n_pop - pop_base, 32'd2);
`else
        check("t6_count", n_pop - pop_base, 32'd4);
`endif

        check("sb_leftover", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
